// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the WM8731 power-up sequencer: FSM state
// encoding, codec register addresses and the default power-up command table.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } seq_state_t;

    localparam int DEFAULT_NUM_CMD = 11;

    // WM8731 register map (7-bit addresses)
    localparam logic [6:0] WM_LEFT_LINE_IN  = 7'h00;
    localparam logic [6:0] WM_RIGHT_LINE_IN = 7'h01;
    localparam logic [6:0] WM_LEFT_HP_OUT   = 7'h02;
    localparam logic [6:0] WM_RIGHT_HP_OUT  = 7'h03;
    localparam logic [6:0] WM_ANALOG_PATH   = 7'h04;
    localparam logic [6:0] WM_DIGITAL_PATH  = 7'h05;
    localparam logic [6:0] WM_POWER_DOWN    = 7'h06;
    localparam logic [6:0] WM_IFACE_FORMAT  = 7'h07;
    localparam logic [6:0] WM_SAMPLING      = 7'h08;
    localparam logic [6:0] WM_ACTIVE        = 7'h09;
    localparam logic [6:0] WM_RESET         = 7'h0F;

    // Default command table entries, packed as {reg[6:0], dat[8:0]}
    localparam logic [15:0] CMD_RESET     = {WM_RESET,         9'h000};
    localparam logic [15:0] CMD_POWER     = {WM_POWER_DOWN,    9'h000};
    localparam logic [15:0] CMD_SAMPLING  = {WM_SAMPLING,      9'h002};
    localparam logic [15:0] CMD_RIGHT_IN  = {WM_RIGHT_LINE_IN, 9'h01A};
    localparam logic [15:0] CMD_LEFT_IN   = {WM_LEFT_LINE_IN,  9'h01A};
    localparam logic [15:0] CMD_FORMAT    = {WM_IFACE_FORMAT,  9'h001};
    localparam logic [15:0] CMD_ACTIVE    = {WM_ACTIVE,        9'h001};
    localparam logic [15:0] CMD_ANALOG    = {WM_ANALOG_PATH,   9'h014};
    localparam logic [15:0] CMD_DIGITAL   = {WM_DIGITAL_PATH,  9'h006};
    localparam logic [15:0] CMD_LEFT_VOL  = {WM_LEFT_HP_OUT,   9'h079};
    localparam logic [15:0] CMD_RIGHT_VOL = {WM_RIGHT_HP_OUT,  9'h079};

    function automatic logic [15:0] default_cmd(input logic [5:0] idx);
        logic [15:0] entry;
        case (idx)
            6'd0:    entry = CMD_RESET;
            6'd1:    entry = CMD_POWER;
            6'd2:    entry = CMD_SAMPLING;
            6'd3:    entry = CMD_RIGHT_IN;
            6'd4:    entry = CMD_LEFT_IN;
            6'd5:    entry = CMD_FORMAT;
            6'd6:    entry = CMD_ACTIVE;
            6'd7:    entry = CMD_ANALOG;
            6'd8:    entry = CMD_DIGITAL;
            6'd9:    entry = CMD_LEFT_VOL;
            6'd10:   entry = CMD_RIGHT_VOL;
            default: entry = 16'h0000;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/i2c_cmd_rom.sv
// Power-up command table: combinational {reg, dat} lookup by table index.
// Indices at or beyond NUM_CMD read as zero.
module i2c_cmd_rom
    import i2c_seq_pkg::*;
#(
    parameter int NUM_CMD = DEFAULT_NUM_CMD,
    parameter int REG_AW  = 7,
    parameter int REG_DW  = 9
) (
    input  logic [5:0]        idx,
    output logic [REG_AW-1:0] reg_addr,
    output logic [REG_DW-1:0] reg_data
);

    logic [15:0] table_mem [NUM_CMD];
    logic [15:0] entry;

    for (genvar gi = 0; gi < NUM_CMD; gi++) begin : g_entry
        assign table_mem[gi] = default_cmd(6'(gi));
    end

    // Explicit compare-select keeps the 6-bit index independent of table depth
    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_CMD; i++) begin
            if (idx == 6'(i)) begin
                entry = table_mem[i];
            end
        end
    end

    assign reg_addr = entry[15:REG_DW];
    assign reg_data = entry[REG_DW-1:0];

endmodule

// File: rtl/i2c_codec_sequencer.sv
// Drives an I2C write controller through the codec power-up table, then serves
// single-register runtime writes. Optional NACK re-send via I2C_SEQ_RETRY_EN.
module i2c_codec_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int         NUM_CMD   = DEFAULT_NUM_CMD,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         REG_AW    = 7,
    parameter int         REG_DW    = 9,
    parameter int         MAX_RETRY = 3
) (
    input  logic              clk_i2c,
    input  logic              reset,
    input  logic              start,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [REG_AW-1:0] upd_reg,
    input  logic [REG_DW-1:0] upd_dat,
    output logic [23:0]       i2c_data,
    output logic              i2c_go,
    input  logic              i2c_end,
    input  logic [2:0]        i2c_ack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [5:0]        cmd_idx
);

    localparam int RETRY_CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef I2C_SEQ_RETRY_EN
    localparam int RETRY_LIMIT = MAX_RETRY;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    seq_state_t           state_reg;
    seq_state_t           state_next;
    logic [5:0]           cmd_idx_reg;
    logic [RETRY_CW-1:0]  retry_cnt_reg;
    logic                 upd_run_reg;
    logic [REG_AW-1:0]    upd_addr_reg;
    logic [REG_DW-1:0]    upd_dat_reg;
    logic [2:0]           ack_reg;
    logic [23:0]          i2c_data_reg;

    logic [REG_AW-1:0]    rom_reg;
    logic [REG_DW-1:0]    rom_dat;
    logic                 nack;
    logic                 can_retry;
    logic                 more_cmds;

    i2c_cmd_rom #(
        .NUM_CMD (NUM_CMD),
        .REG_AW  (REG_AW),
        .REG_DW  (REG_DW)
    ) u_cmd_rom (
        .idx      (cmd_idx_reg),
        .reg_addr (rom_reg),
        .reg_data (rom_dat)
    );

    assign nack      = |ack_reg;
    // The counter never passes the limit, so inequality is the "below limit" test
    assign can_retry = (retry_cnt_reg != RETRY_CW'(RETRY_LIMIT));
    assign more_cmds = ({26'd0, cmd_idx_reg} + 32'd1) < 32'(NUM_CMD);

    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_WAIT;
            ST_WAIT:  if (i2c_end) state_next = ST_CHECK;
            ST_CHECK: begin
                if (!nack)          state_next = ST_NEXT;
                else if (can_retry) state_next = ST_LOAD;
                else                state_next = ST_ERR;
            end
            ST_NEXT:  state_next = (!upd_run_reg && more_cmds) ? ST_LOAD : ST_DONE;
            ST_DONE:  if (start || upd_valid) state_next = ST_LOAD;
            ST_ERR:   if (start) state_next = ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: table index, retry count, latched update payload, transfer word
    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            cmd_idx_reg   <= '0;
            retry_cnt_reg <= '0;
            upd_run_reg   <= 1'b0;
            upd_addr_reg  <= '0;
            upd_dat_reg   <= '0;
            ack_reg       <= '0;
            i2c_data_reg  <= '0;
        end else begin
            if (state_reg == ST_WAIT && i2c_end) begin
                ack_reg <= i2c_ack;
            end
            case (state_reg)
                ST_IDLE: begin
                    cmd_idx_reg   <= '0;
                    retry_cnt_reg <= '0;
                    upd_run_reg   <= 1'b0;
                end
                ST_LOAD: begin
                    i2c_data_reg <= upd_run_reg ? {DEV_ADDR, 1'b0, upd_addr_reg, upd_dat_reg}
                                                : {DEV_ADDR, 1'b0, rom_reg, rom_dat};
                end
                ST_CHECK: begin
                    if (!nack) begin
                        retry_cnt_reg <= '0;
                    end else if (can_retry) begin
                        retry_cnt_reg <= retry_cnt_reg + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (!upd_run_reg && more_cmds) begin
                        cmd_idx_reg <= cmd_idx_reg + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        cmd_idx_reg   <= '0;
                        retry_cnt_reg <= '0;
                        upd_run_reg   <= 1'b0;
                    end else if (upd_valid) begin
                        upd_run_reg  <= 1'b1;
                        upd_addr_reg <= upd_reg;
                        upd_dat_reg  <= upd_dat;
                    end
                end
                ST_ERR: begin
                    if (start) begin
                        cmd_idx_reg   <= '0;
                        retry_cnt_reg <= '0;
                        upd_run_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // i2c_go is raised on WAIT entry, the same edge that presents the word loaded in LOAD
    always_comb begin
        i2c_go    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        upd_ready = 1'b0;
        case (state_reg)
            ST_LOAD:  busy = 1'b1;
            ST_WAIT:  begin
                busy   = 1'b1;
                i2c_go = 1'b1;
            end
            ST_CHECK: busy = 1'b1;
            ST_NEXT:  busy = 1'b1;
            ST_DONE:  begin
                done      = 1'b1;
                upd_ready = 1'b1;
            end
            ST_ERR:   error = 1'b1;
            default:  ;
        endcase
    end

    assign i2c_data = i2c_data_reg;
    assign cmd_idx  = cmd_idx_reg;

endmodule

// File: tb/tb_i2c_codec_sequencer.sv
// Scoreboard bench for i2c_codec_sequencer: expected transfer words are queued
// by the stimulus, a monitor pops them on every rising i2c_go.
module tb_i2c_codec_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [6:0]  upd_reg = '0;
    logic [8:0]  upd_dat = '0;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic [2:0]  i2c_ack = 3'b000;
    logic        busy, done, error;
    logic [5:0]  cmd_idx;

    logic        end_model = 1'b0;
    logic        end_spur = 1'b0;
    assign i2c_end = end_model | end_spur;

    int checks = 0;
    int passes = 0;

    logic [23:0] exp_q[$];

    // Controller model knobs (written only by the stimulus process)
    int  nack_idx = -1;
    int  nack_want = 0;
    int  lat_min = 5;
    int  lat_max = 5;

    int unsigned ref_reg [11] = '{'h0F, 'h06, 'h08, 'h01, 'h00, 'h07, 'h09, 'h04, 'h05, 'h02, 'h03};
    int unsigned ref_dat [11] = '{'h000, 'h000, 'h002, 'h01A, 'h01A, 'h001, 'h001, 'h014, 'h006, 'h079, 'h079};

    i2c_codec_sequencer dut (
        .clk_i2c   (clk),
        .reset     (reset),
        .start     (start),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_reg   (upd_reg),
        .upd_dat   (upd_dat),
        .i2c_data  (i2c_data),
        .i2c_go    (i2c_go),
        .i2c_end   (i2c_end),
        .i2c_ack   (i2c_ack),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cmd_idx   (cmd_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] word(input int unsigned r, input int unsigned d);
        return 24'('h1A * (2 ** 17) + r * (2 ** 9) + d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_table(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(word(ref_reg[i], ref_dat[i]));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_settle(input string name, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            if (done || error) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (hit) passes++;
        else $display("FAIL %s: timeout after %0d cycles, done=%0b error=%0b", name, budget, done, error);
    endtask

    task automatic do_update(input logic [6:0] r, input logic [8:0] d);
        exp_q.push_back(word(r, d));
        @(negedge clk);
        check("upd_ready_in_done", upd_ready, 1);
        upd_valid = 1'b1;
        upd_reg   = r;
        upd_dat   = d;
        @(negedge clk);
        upd_valid = 1'b0;
        wait_settle("update_run", 500);
        check("update_done", done, 1);
        check("update_idx_kept", cmd_idx, 10);
        check("update_q_empty", exp_q.size(), 0);
        $display("update reg=%02h dat=%03h -> done=%0b cmd_idx=%0d", r, d, done, cmd_idx);
    endtask

    // Controller model: answers each rising i2c_go after a latency, NACKing
    // the selected index nack_want times per run (counted from start)
    int  lat_cnt = 0;
    bit  pend = 0;
    logic go_prev_m = 1'b0;
    int  nack_given = 0;
    always @(negedge clk) begin
        end_model = 1'b0;
        if (start) nack_given = 0;
        if (reset) begin
            pend = 0;
        end else if (pend) begin
            if (lat_cnt > 1) begin
                lat_cnt--;
            end else begin
                end_model = 1'b1;
                pend = 0;
                if (nack_given < nack_want && int'(cmd_idx) == nack_idx) begin
                    i2c_ack = 3'($urandom_range(1, 7));
                    nack_given++;
                end else begin
                    i2c_ack = 3'b000;
                end
            end
        end else if (i2c_go && !go_prev_m) begin
            pend = 1;
            lat_cnt = int'($urandom_range(lat_min, lat_max));
        end
        go_prev_m = i2c_go;
    end

    // Monitor: every new transfer must match the head of the scoreboard
    logic        go_prev = 1'b0;
    logic [23:0] held;
    always @(negedge clk) begin
        if (i2c_go && !go_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_transfer: got %06h expected none", i2c_data);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("transfer_data", i2c_data, e);
                $display("transfer idx=%0d data=%06h expected=%06h", cmd_idx, i2c_data, e);
            end
            held = i2c_data;
        end else if (i2c_go && go_prev) begin
            check("data_stable_in_wait", i2c_data, held);
        end
        go_prev = i2c_go;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passes, checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_go", i2c_go, 0);
        check("rst_data", i2c_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_upd_ready", upd_ready, 0);
        check("rst_idx", cmd_idx, 0);

        // Power-up run
        push_table(0, 10);
        reset = 1'b0;
        wait_settle("powerup", 2000);
        check("powerup_done", done, 1);
        check("powerup_idx", cmd_idx, 10);
        check("powerup_error", error, 0);
        check("powerup_busy", busy, 0);
        check("powerup_q_empty", exp_q.size(), 0);

        // Stray i2c_end while idle in DONE
        @(negedge clk);
        end_spur = 1'b1;
        @(negedge clk);
        end_spur = 1'b0;
        repeat (4) @(negedge clk);
        check("spurious_end_done", done, 1);
        check("spurious_end_go", i2c_go, 0);

        // Runtime updates: fixed one, then randomized with random latency
        do_update(7'h02, 9'h07F);
        lat_min = 1;
        lat_max = 8;
        for (int k = 0; k < 4; k++) do_update(7'($urandom_range(0, 127)), 9'($urandom_range(0, 511)));

        // start and upd_valid together: only the table rerun happens
        push_table(0, 10);
        @(negedge clk);
        start = 1'b1;
        upd_valid = 1'b1;
        upd_reg = 7'h55;
        upd_dat = 9'h1AA;
        @(negedge clk);
        start = 1'b0;
        upd_valid = 1'b0;
        wait_settle("start_vs_update", 2000);
        check("start_wins_idx", cmd_idx, 10);
        check("start_wins_q_empty", exp_q.size(), 0);

`ifdef I2C_SEQ_RETRY_EN
        // Two NACKs on index 3: resent, sequence completes
        nack_idx = 3;
        nack_want = 2;
        push_table(0, 3);
        push_table(3, 3);
        push_table(3, 10);
        pulse_start();
        wait_settle("retry_recover", 3000);
        check("retry_recover_done", done, 1);
        check("retry_recover_error", error, 0);
        check("retry_recover_idx", cmd_idx, 10);
        check("retry_recover_q_empty", exp_q.size(), 0);

        // Four NACKs on index 3: original plus three resends, then ERR
        nack_want = 4;
        push_table(0, 3);
        push_table(3, 3);
        push_table(3, 3);
        push_table(3, 3);
        pulse_start();
        wait_settle("retry_exhaust", 3000);
        repeat (5) @(negedge clk);
        check("retry_exhaust_error", error, 1);
        check("retry_exhaust_idx", cmd_idx, 3);
        check("retry_exhaust_go", i2c_go, 0);
        check("retry_exhaust_q_empty", exp_q.size(), 0);
`else
        // First NACK on index 5 goes straight to ERR
        nack_idx = 5;
        nack_want = 1;
        push_table(0, 5);
        pulse_start();
        wait_settle("nack5", 2000);
        repeat (5) @(negedge clk);
        check("nack5_error", error, 1);
        check("nack5_idx", cmd_idx, 5);
        check("nack5_go", i2c_go, 0);
        check("nack5_done", done, 0);
        check("nack5_q_empty", exp_q.size(), 0);

        // NACK on a random index, restarted from ERR
        nack_idx = int'($urandom_range(0, 10));
        push_table(0, nack_idx);
        pulse_start();
        wait_settle("nack_rand", 2000);
        check("nack_rand_error", error, 1);
        check("nack_rand_idx", cmd_idx, 32'(nack_idx));
        check("nack_rand_q_empty", exp_q.size(), 0);
`endif

        // Restart from ERR with a clean controller
        nack_want = 0;
        push_table(0, 10);
        pulse_start();
        wait_settle("restart_after_err", 2000);
        check("restart_done", done, 1);
        check("restart_error", error, 0);
        check("restart_idx", cmd_idx, 10);

        // Reset during WAIT of index 6
        push_table(0, 6);
        pulse_start();
        begin
            bit hit = 0;
            for (int i = 0; i < 2000; i++) begin
                if (i2c_go && cmd_idx == 6) begin
                    hit = 1;
                    break;
                end
                @(negedge clk);
            end
            checks++;
            if (hit) passes++;
            else $display("FAIL reach_wait_idx6: timeout, cmd_idx=%0d go=%0b", cmd_idx, i2c_go);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_go", i2c_go, 0);
        check("midreset_busy", busy, 0);
        check("midreset_idx", cmd_idx, 0);
        repeat (2) @(negedge clk);
        push_table(0, 10);
        reset = 1'b0;
        wait_settle("after_reset", 2000);
        check("after_reset_done", done, 1);
        check("after_reset_idx", cmd_idx, 10);
        check("after_reset_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
